// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: state and owner encodings,
// default widths and a counter-width helper.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned DEF_TIMEOUT    = 16;

    // Starvation counter width covers the full legal STARVE_MAX range (1..15)
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count
);

    // Count up to limit and hold there until cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != limit)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch I, load/store D) in front of a single-port memory.
// D has fixed priority; after STARVE_MAX consecutive contended losses I is forced
// to win. Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    // fetch requester
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    // load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    // memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                arb_err
);

    state_t              state;
    owner_t              owner;
    logic [STARVE_W-1:0] starve_cnt;

    logic busy_c;
    logic starve_hit_c;
    logic grant_i_c;
    logic grant_d_c;
    logic expire_c;
    logic done_c;

    // TIMEOUT is only meaningful with the watchdog; zero is never a valid setting
    if (TIMEOUT == 0) begin : g_bad_timeout
    end

    // Arbitration: D wins unless I has lost STARVE_MAX contended rounds in a row
    assign busy_c       = (state != ST_IDLE);
    assign starve_hit_c = (starve_cnt == STARVE_W'(STARVE_MAX));
    assign grant_i_c    = !busy_c && if_req && (!d_req || starve_hit_c);
    assign grant_d_c    = !busy_c && d_req && !(if_req && starve_hit_c);

    // Consecutive contended losses of the fetch side
    arb_sat_counter #(
        .WIDTH (STARVE_W)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .clr   (grant_i_c),
        .inc   (grant_d_c && if_req),
        .limit (STARVE_W'(STARVE_MAX)),
        .count (starve_cnt)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = cnt_width(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;

    // BUSY cycle counter, held at zero while idle so every transaction starts fresh
    arb_sat_counter #(
        .WIDTH (WD_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (!busy_c),
        .inc   (busy_c),
        .limit (WD_W'(TIMEOUT - 1)),
        .count (wd_cnt)
    );

    // Expire on the TIMEOUT-th BUSY cycle; a coincident mem_ack is a normal completion
    assign expire_c = busy_c && (wd_cnt == WD_W'(TIMEOUT - 1)) && !mem_ack;
`else
    assign expire_c = 1'b0;
`endif

    // Completion is visible to the owner in the same cycle as mem_ack (or expiry)
    assign done_c   = busy_c && (mem_ack || expire_c);
    assign if_ack   = (owner == OWN_I) && done_c;
    assign d_ack    = (owner == OWN_D) && done_c;
    assign if_rdata = (if_ack && mem_ack) ? mem_rdata : '0;
    assign d_rdata  = (d_ack && mem_ack) ? mem_rdata : '0;
    assign arb_err  = expire_c;

    // Transaction sequencer: latch the winner into mem_* and hold until completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d_c) begin
                        state     <= ST_BUSY_D;
                        owner     <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_i_c) begin
                        state     <= ST_BUSY_I;
                        owner     <= OWN_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= '1;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (done_c) begin
                        state   <= ST_IDLE;
                        owner   <= OWN_NONE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    owner   <= OWN_NONE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
